// File: rtl/exec_alu_pkg.sv
// exec_alu_pkg: op encodings, FSM states and helpers shared by exec_alu and its multiply/divide engine.
package exec_alu_pkg;
    localparam int OP_W = 5;

    typedef enum logic [OP_W-1:0] {
        OP_ADD    = 5'd0,
        OP_SUB    = 5'd1,
        OP_SLL    = 5'd2,
        OP_SLT    = 5'd3,
        OP_SLTU   = 5'd4,
        OP_XOR    = 5'd5,
        OP_SRL    = 5'd6,
        OP_SRA    = 5'd7,
        OP_OR     = 5'd8,
        OP_AND    = 5'd9,
        OP_MUL    = 5'd16,
        OP_MULH   = 5'd17,
        OP_MULHSU = 5'd18,
        OP_MULHU  = 5'd19,
        OP_DIV    = 5'd20,
        OP_DIVU   = 5'd21,
        OP_REM    = 5'd22,
        OP_REMU   = 5'd23
    } alu_op_e;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    function automatic logic is_muldiv(input logic [OP_W-1:0] op);
        return op[OP_W-1:3] == 2'b10;
    endfunction
endpackage

// File: rtl/exec_alu_mdu.sv
// exec_alu_mdu: iterative shift-add multiplier / restoring divider on operand magnitudes, XLEN steps per op.
module exec_alu_mdu
    import exec_alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [OP_W-1:0] op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] res
);
    localparam int CW = $clog2(XLEN);

    logic              run, div_op, hi_sel, rem_sel, neg_p, neg_r;
    logic              sgn_a, sgn_b, ge;
    logic [CW-1:0]     cnt;
    logic [XLEN-1:0]   m, mag_a, mag_b, t2, q, r;
    logic [XLEN:0]     sum, t;
    logic [2*XLEN-1:0] p, nxt, prod;

    always_comb begin
        sgn_a = a[XLEN-1] && (op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
        sgn_b = b[XLEN-1] && (op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM});
        mag_a = sgn_a ? -a : a;
        mag_b = sgn_b ? -b : b;
        sum   = {1'b0, p[2*XLEN-1:XLEN]} + (p[0] ? {1'b0, m} : '0);
        t     = {p[2*XLEN-1:XLEN], p[XLEN-1]};
        ge    = t >= {1'b0, m};
        t2    = t[XLEN-1:0] - (ge ? m : '0);
        nxt   = div_op ? {t2, p[XLEN-2:0], ge} : {sum, p[XLEN-1:1]};
        prod  = neg_p ? -nxt : nxt;
        q     = neg_p ? -nxt[XLEN-1:0] : nxt[XLEN-1:0];
        r     = neg_r ? -nxt[2*XLEN-1:XLEN] : nxt[2*XLEN-1:XLEN];
        res   = div_op ? (rem_sel ? r : q) : (hi_sel ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0]);
        done  = run && cnt == CW'(XLEN - 1);
    end

    // Remainder lives in the upper half of p, quotient bits shift into the lower half.
    always_ff @(posedge clk) begin
        if (rst) begin
            run <= 1'b0;
            cnt <= '0;
        end else if (start) begin
            run     <= 1'b1;
            cnt     <= '0;
            p       <= {{XLEN{1'b0}}, mag_a};
            m       <= mag_b;
            div_op  <= op[2];
            hi_sel  <= op[1:0] != 2'b00;
            rem_sel <= op[1];
            neg_p   <= sgn_a ^ sgn_b;
            neg_r   <= sgn_a;
        end else if (run) begin
            p   <= nxt;
            cnt <= cnt + 1'b1;
            run <= !done;
        end
    end
endmodule

// File: rtl/exec_alu.sv
// exec_alu: handshaked EX-stage ALU, RV32I reg-reg ops in one cycle; iterative M-extension ops
// are built only when EXEC_ALU_MULDIV_EN is defined.
module exec_alu
    import exec_alu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int OP_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OP_W-1:0] op,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            illegal_op,
    output logic            busy
);
    localparam int SW = $clog2(XLEN);

    state_e          state, state_n;
    logic [XLEN-1:0] quick, result_n;
    logic [SW-1:0]   sh;
    logic            quick_ill, illegal_n, accept;

    assign sh        = src2[SW-1:0];
    assign out_valid = state == DONE;
    assign in_ready  = state == IDLE || (state == DONE && out_ready);
    assign accept    = in_valid && in_ready;

`ifdef EXEC_ALU_MULDIV_EN
    logic            div_zero, div_ovf, slow, start, mdu_done;
    logic [XLEN-1:0] mdu_res;

    assign div_zero = src2 == '0;
    assign div_ovf  = src1 == {1'b1, {(XLEN-1){1'b0}}} && src2 == '1;
    // Divide-by-zero and signed overflow bypass the engine with a one-cycle result.
    assign slow     = is_muldiv(op) && !(op[2] && (div_zero || (div_ovf && !op[0])));
    assign start    = accept && slow;
    assign busy     = state == CALC;

    exec_alu_mdu #(.XLEN(XLEN)) u_mdu (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .op   (op),
        .a    (src1),
        .b    (src2),
        .done (mdu_done),
        .res  (mdu_res)
    );
`else
    assign busy = 1'b0;
`endif

    always_comb begin
        quick     = '0;
        quick_ill = 1'b0;
        case (op)
            OP_ADD:  quick = src1 + src2;
            OP_SUB:  quick = src1 - src2;
            OP_SLL:  quick = src1 << sh;
            OP_SLT:  quick = XLEN'($signed(src1) < $signed(src2));
            OP_SLTU: quick = XLEN'(src1 < src2);
            OP_XOR:  quick = src1 ^ src2;
            OP_SRL:  quick = src1 >> sh;
            OP_SRA:  quick = $signed(src1) >>> sh;
            OP_OR:   quick = src1 | src2;
            OP_AND:  quick = src1 & src2;
`ifdef EXEC_ALU_MULDIV_EN
            OP_DIV:  quick = div_zero ? '1 : src1;
            OP_DIVU: quick = '1;
            OP_REM:  quick = div_zero ? src1 : '0;
            OP_REMU: quick = src1;
`endif
            default: quick_ill = 1'b1;
        endcase
    end

    always_comb begin
        state_n   = state;
        result_n  = result;
        illegal_n = illegal_op;
        if (state == DONE && out_ready) state_n = IDLE;
`ifdef EXEC_ALU_MULDIV_EN
        if (start) state_n = CALC;
        else
`endif
        if (accept) begin
            state_n   = DONE;
            result_n  = quick;
            illegal_n = quick_ill;
        end
`ifdef EXEC_ALU_MULDIV_EN
        if (state == CALC && mdu_done) begin
            state_n   = DONE;
            result_n  = mdu_res;
            illegal_n = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            result     <= '0;
            illegal_op <= 1'b0;
        end else begin
            state      <= state_n;
            result     <= result_n;
            illegal_op <= illegal_n;
        end
    end
endmodule

// File: tb/tb_exec_alu.sv
// tb_exec_alu: scoreboard bench for exec_alu; expectations follow EXEC_ALU_MULDIV_EN like the DUT build.
module tb_exec_alu;
    import exec_alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready, illegal_op, busy;
    logic [4:0]  op;
    logic [31:0] src1, src2, result;

    typedef struct {
        logic [31:0] res;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    exec_alu #(.XLEN(32), .OP_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .src1      (src1),
        .src2      (src2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .illegal_op(illegal_op),
        .busy      (busy)
    );

    function automatic exp_t model(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      sp;
        logic [63:0] up;
        logic        ovf;
        e.res = 32'd0;
        e.ill = 1'b0;
        ovf   = a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
        case (o)
            5'd0: e.res = a + b;
            5'd1: e.res = a - b;
            5'd2: e.res = a << b[4:0];
            5'd3: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            5'd4: e.res = (a < b) ? 32'd1 : 32'd0;
            5'd5: e.res = a ^ b;
            5'd6: e.res = a >> b[4:0];
            5'd7: e.res = $signed(a) >>> b[4:0];
            5'd8: e.res = a | b;
            5'd9: e.res = a & b;
`ifdef EXEC_ALU_MULDIV_EN
            5'd16: begin sp = longint'($signed(a)) * longint'($signed(b)); e.res = sp[31:0]; end
            5'd17: begin sp = longint'($signed(a)) * longint'($signed(b)); e.res = sp[63:32]; end
            5'd18: begin sp = longint'($signed(a)) * longint'({32'd0, b}); e.res = sp[63:32]; end
            5'd19: begin up = {32'd0, a} * {32'd0, b}; e.res = up[63:32]; end
            5'd20: e.res = (b == 0) ? 32'hFFFF_FFFF : ovf ? a : $signed(a) / $signed(b);
            5'd21: e.res = (b == 0) ? 32'hFFFF_FFFF : a / b;
            5'd22: e.res = (b == 0) ? a : ovf ? 32'd0 : $signed(a) % $signed(b);
            5'd23: e.res = (b == 0) ? a : a % b;
`endif
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    function automatic int exp_lat(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
`ifdef EXEC_ALU_MULDIV_EN
        if (o >= 5'd16 && o <= 5'd19) return 33;
        if (o >= 5'd20 && o <= 5'd23) begin
            if (b == 0) return 1;
            if ((o == 5'd20 || o == 5'd22) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
            return 33;
        end
`endif
        return 1;
    endfunction

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            exp_t e;
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: result=%h illegal=%b with nothing expected", result, illegal_op);
            end else begin
                e = sb.pop_front();
                if (result !== e.res || illegal_op !== e.ill) begin
                    bad++;
                    $display("FAIL sb_result: got %h/%b want %h/%b", result, illegal_op, e.res, e.ill);
                end
            end
        end
    end

    task automatic issue(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        op = o; src1 = a; src2 = b; in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        total++;
        if (!in_ready) begin
            bad++;
            $display("FAIL issue_timeout: in_ready=%b want 1", in_ready);
        end
        @(posedge clk);
        sb.push_back(model(o, a, b));
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = '0; src1 = '0; src2 = '0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        total++; if (result !== 32'd0) begin bad++; $display("FAIL rst_result: got %h want 0", result); end
        total++; if (illegal_op !== 1'b0) begin bad++; $display("FAIL rst_illegal: got %b want 0", illegal_op); end
        rst = 1'b0;
        @(posedge clk); #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_single();
        int lat;
        logic [4:0] o;
        issue(OP_SUB, 32'd5, 32'd7);
        wait_out(lat);
        total++; if (lat !== 1) begin bad++; $display("FAIL sub_latency: got %0d want 1", lat); end
        total++; if (result !== 32'hFFFF_FFFE) begin bad++; $display("FAIL sub_result: got %h want fffffffe", result); end
        issue(OP_SRA, 32'h8000_0000, 32'h24);
        wait_out(lat);
        total++; if (result !== 32'hF800_0000) begin bad++; $display("FAIL sra_result: got %h want f8000000", result); end
        for (int i = 0; i < 24; i++) begin
            o = 5'($urandom_range(0, 9));
            issue(o, $urandom, (i % 3 == 0) ? $urandom : $urandom_range(0, 40));
            wait_out(lat);
            total++; if (lat !== 1) begin bad++; $display("FAIL rand_latency op=%0d: got %0d want 1", o, lat); end
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        op = OP_ADD; src1 = 32'd3; src2 = 32'd4; in_valid = 1'b1;
        @(posedge clk);
        sb.push_back(model(OP_ADD, 32'd3, 32'd4));
        #1;
        total++; if (out_valid !== 1'b1 || result !== 32'd7) begin bad++; $display("FAIL b2b_add: got %b/%h want 1/00000007", out_valid, result); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready1: got %b want 1", in_ready); end
        op = OP_XOR; src1 = 32'hF0; src2 = 32'hFF;
        @(posedge clk);
        sb.push_back(model(OP_XOR, 32'hF0, 32'hFF));
        #1;
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || result !== 32'h0F) begin bad++; $display("FAIL b2b_xor: got %b/%h want 1/0000000f", out_valid, result); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready2: got %b want 1", in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_muldiv();
        int lat;
`ifdef EXEC_ALU_MULDIV_EN
        logic ok = 1'b1;
        logic [4:0] o;
        logic [31:0] a, b;
        issue(OP_MULH, 32'h8000_0000, 32'd2);
        op = OP_ADD; src1 = 32'd1; src2 = 32'd1; in_valid = 1'b1;
        lat = 1;
        while (!out_valid && lat < 100) begin
            if (busy !== 1'b1 || in_ready !== 1'b0) ok = 1'b0;
            @(posedge clk); #1; lat++;
        end
        in_valid = 1'b0;
        total++; if (lat !== 33) begin bad++; $display("FAIL mulh_latency: got %0d want 33", lat); end
        total++; if (result !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mulh_result: got %h want ffffffff", result); end
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL calc_busy_ready: got %b want 1", ok); end
        for (int i = 0; i < 16; i++) begin
            o = 5'(16 + (i % 8));
            a = (i < 8) ? $urandom : $urandom_range(0, 1000);
            b = (i % 5 == 4) ? 32'hFFFF_FFF9 : $urandom_range(1, 50000);
            issue(o, a, b);
            wait_out(lat);
            total++; if (lat !== exp_lat(o, a, b)) begin bad++; $display("FAIL md_latency op=%0d: got %0d want %0d", o, lat, exp_lat(o, a, b)); end
        end
`else
        issue(OP_MUL, 32'd3, 32'd4);
        wait_out(lat);
        total++; if (lat !== 1) begin bad++; $display("FAIL mul_off_latency: got %0d want 1", lat); end
        total++; if (illegal_op !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL mul_off_flags: got ill=%b busy=%b want 1/0", illegal_op, busy); end
`endif
    endtask

    task automatic test_div_special();
        logic [4:0]  ops[4]  = '{OP_DIV, OP_REM, OP_DIVU, OP_REMU};
        logic [31:0] as[4]   = '{32'd123, 32'h8000_0000, 32'd100, 32'd100};
        logic [31:0] bs[4]   = '{32'd0, 32'hFFFF_FFFF, 32'd7, 32'd7};
`ifdef EXEC_ALU_MULDIV_EN
        logic [31:0] want[4] = '{32'hFFFF_FFFF, 32'd0, 32'd14, 32'd2};
        int          lats[4] = '{1, 1, 33, 33};
`else
        logic [31:0] want[4] = '{32'd0, 32'd0, 32'd0, 32'd0};
        int          lats[4] = '{1, 1, 1, 1};
`endif
        int lat;
        for (int i = 0; i < 4; i++) begin
            issue(ops[i], as[i], bs[i]);
            wait_out(lat);
            total++; if (lat !== lats[i]) begin bad++; $display("FAIL divsp_latency %0d: got %0d want %0d", i, lat, lats[i]); end
            total++; if (result !== want[i]) begin bad++; $display("FAIL divsp_result %0d: got %h want %h", i, result, want[i]); end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [31:0] hold;
        out_ready = 1'b0;
        issue(OP_DIV, 32'hFFFF_FF9C, 32'd7);
        wait_out(lat);
        hold = result;
`ifdef EXEC_ALU_MULDIV_EN
        total++; if (hold !== 32'hFFFF_FFF2) begin bad++; $display("FAIL bp_value: got %h want fffffff2", hold); end
`else
        total++; if (hold !== 32'd0 || illegal_op !== 1'b1) begin bad++; $display("FAIL bp_value: got %h/%b want 0/1", hold, illegal_op); end
`endif
        op = OP_ADD; src1 = 32'd9; src2 = 32'd9; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            total++;
            if (out_valid !== 1'b1 || result !== hold || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold cycle %0d: got v=%b r=%h rdy=%b want 1/%h/0", i, out_valid, result, in_ready, hold);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_release: got %b want 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        logic quiet = 1'b1;
`ifdef EXEC_ALU_MULDIV_EN
        issue(OP_DIVU, 32'd1000, 32'd3);
        repeat (5) @(posedge clk);
        #1;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy: got %b want 1", busy); end
`else
        out_ready = 1'b0;
        issue(OP_ADD, 32'd1, 32'd2);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL mid_out_valid: got %b want 1", out_valid); end
`endif
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        out_ready = 1'b1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid: got %b want 0", out_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_ready: got %b want 1", in_ready); end
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) quiet = 1'b0;
        end
        total++; if (quiet !== 1'b1) begin bad++; $display("FAIL mid_rst_quiet: got %b want 1", quiet); end
    endtask

    task automatic test_illegal();
        int lat;
        issue(5'd12, 32'h1234, 32'h5678);
        wait_out(lat);
        total++; if (lat !== 1) begin bad++; $display("FAIL illegal_latency: got %0d want 1", lat); end
        total++; if (result !== 32'd0 || illegal_op !== 1'b1) begin bad++; $display("FAIL illegal_out: got %h/%b want 0/1", result, illegal_op); end
        issue(5'd31, 32'hFFFF, 32'd1);
        wait_out(lat);
        issue(OP_OR, 32'hA0, 32'h0B);
        wait_out(lat);
        total++; if (illegal_op !== 1'b0 || result !== 32'hAB) begin bad++; $display("FAIL illegal_clear: got %h/%b want 000000ab/0", result, illegal_op); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_muldiv();
        test_div_special();
        test_backpressure();
        test_reset_mid();
        test_illegal();
        repeat (3) @(posedge clk);
        #1;
        total++; if (sb.size() != 0) begin bad++; $display("FAIL sb_drain: got %0d pending want 0", sb.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/exec_alu.md
Name: exec_alu

Overview:
- Parametrised, handshaked successor to the core's combinational ALU; sits in the EX stage between decode/regfile read and writeback.
- Executes the RV32I register-register ALU ops in one registered cycle.
- Adds iterative RV M-extension multiply/divide (XLEN-cycle shift-add / restoring), gated by a macro.
- Width is generic (XLEN), so the same block serves RV32 and RV64 builds.

Parameters:
- XLEN, 32, datapath width in bits (power of two, >= 8).
- OP_W, 5, width of the op field; fixed by the package op enum.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  block can accept a request this cycle
- op  in  OP_W  operation (alu_op_e)
- src1  in  XLEN  operand 1 (rs1)
- src2  in  XLEN  operand 2 (rs2 or immediate, selected upstream)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  XLEN  result, held stable while out_valid && !out_ready
- illegal_op  out  1  qualifies result; op code was unsupported
- busy  out  1  an iterative op is in progress

Behaviour:
- Reset: synchronous on rst, sampled at the clk rising edge. Values: state=IDLE, out_valid=0, result=0, illegal_op=0, busy=0. in_ready reads 1 the cycle after reset.
- Reset mid-operation aborts any in-flight op with no output.
- States:
  - IDLE: accepts requests.
  - CALC: iterative op in progress, busy=1.
  - DONE: out_valid=1, output held.
- Handshake: in_ready = (state==IDLE) || (state==DONE && out_ready).
  - Accept = in_valid && in_ready.
  - Accepting in DONE while out_ready is high allows back-to-back issue.
- Single-cycle ops, encodings 0-9:
  - ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
  - Result is registered at accept; out_valid rises the next cycle (latency 1).
  - Shift amount = src2[$clog2(XLEN)-1:0]; upper bits are ignored.
  - SRA is arithmetic on signed src1.
  - SLT/SLTU return 1 or 0, zero-extended to XLEN.
  - ADD/SUB wrap modulo 2^XLEN.
- Iterative ops, encodings 16-23:
  - MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
  - Operands are converted to magnitudes at accept. XLEN iterations run in CALC, then sign fix-up happens on entry to DONE.
  - out_valid asserts exactly XLEN+1 cycles after the accept cycle.
  - MUL returns the low XLEN bits; the MULH* ops return the high XLEN bits of the 2*XLEN product.
- Divide special cases (fast path, latency 1, no CALC):
  - Divisor 0: DIV/DIVU result = all ones; REM/REMU result = src1.
  - Signed overflow (src1 = most-negative, src2 = -1): DIV result = src1; REM result = 0.
- Unknown op: result=0, illegal_op=1, latency 1.
- Backpressure: in DONE with out_ready=0, result, illegal_op and out_valid hold; in_ready=0.
- Requests are not accepted during CALC; in_valid is ignored there.

Optional Feature:
- Macro: EXEC_ALU_MULDIV_EN.
- Defined: iterative ops behave as specified above.
- Undefined:
  - CALC state and the multiply/divide datapath are not built.
  - Op codes 16-23 are treated as unknown: result=0, illegal_op=1, latency 1.
  - busy is tied to 0.

Decomposition:
- Package exec_alu_pkg:
  - typedef enum alu_op_e, encodings as listed.
  - typedef enum state_e {IDLE, CALC, DONE}.
  - Localparam OP_W=5.
  - Function is_muldiv(op).
- Sub-module exec_alu_mdu: iterative multiply/divide engine.
  - Interface: start, op, a, b, done, res.
  - Holds the iteration counter, partial-product/remainder registers and sign fix-up.
  - Instantiated only under EXEC_ALU_MULDIV_EN.

Test Plan (XLEN=32):
- Single-cycle ops:
  - SUB src1=5, src2=7 -> result 0xFFFFFFFE, out_valid one cycle after accept.
  - SRA src1=0x80000000, src2=0x24 (shift 4) -> 0xF8000000.
- Back-to-back issue: ADD then XOR issued with out_ready=1 held high -> two results on consecutive out_valid cycles, in_ready never drops.
- MULH src1=0x80000000, src2=2 -> 0xFFFFFFFF; out_valid exactly 33 cycles after accept; busy=1 throughout CALC; in_ready=0 throughout CALC.
- Divide special cases:
  - DIV src2=0 -> 0xFFFFFFFF at latency 1.
  - REM 0x80000000 / 0xFFFFFFFF -> 0.
  - DIVU 100/7 -> 14.
  - REMU 100/7 -> 2.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles after DIV completes -> result and out_valid stable throughout.
  - Assert rst mid-CALC -> next cycle out_valid=0, busy=0, in_ready=1.
- Illegal op: op=12 -> result 0, illegal_op=1. Build without EXEC_ALU_MULDIV_EN: op=MUL -> illegal_op=1 at latency 1.
